// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: reads the PC, fetches from instruction memory and buffers words for the decoder.
// A jump flushes the buffer and redirects the next fetch to the jump target.
module ins_fetch_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int INS_WIDTH  = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_jump,
  output logic                  o_ins_pc_oen,
  output logic                  o_mem_rd,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_rdy,
  input  logic [INS_WIDTH-1:0]  i_mem_data,
  output logic [INS_WIDTH-1:0]  o_ins,
  output logic                  o_ins_valid,
  input  logic                  i_ins_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t                state_reg;
  logic [PTR_W:0]        count_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic                  jmp_pend_reg;
  logic [DATA_WIDTH-1:0] jmp_addr_reg;
  logic                  noadv_reg;
  logic                  mem_rd_reg;
  logic [DATA_WIDTH-1:0] mem_addr_reg;
  logic [INS_WIDTH-1:0]  mem_reg [FIFO_DEPTH];

  logic push;
  logic pop;
  logic issue;

  assign push         = (state_reg == REQ) & i_mem_rdy & ~i_jump;
  // The calculator already stepped past a jump target, so the first fetch after a jump stays silent.
  assign o_ins_pc_oen = push & ~noadv_reg;
  assign o_ins_valid  = (count_reg != '0) & ~i_jump;
  assign pop          = o_ins_valid & i_ins_ready;
  assign issue        = (state_reg == IDLE) & ~i_jump & (count_reg < (PTR_W + 1)'(FIFO_DEPTH));
  assign o_ins        = mem_reg[rd_ptr_reg];
  assign o_mem_rd     = mem_rd_reg;
  assign o_mem_addr   = mem_addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      jmp_pend_reg <= 1'b0;
      jmp_addr_reg <= '0;
      noadv_reg    <= 1'b0;
      mem_rd_reg   <= 1'b0;
      mem_addr_reg <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (i_jump) begin
        jmp_addr_reg <= i_pc;
        jmp_pend_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (issue) begin
            mem_rd_reg   <= 1'b1;
            mem_addr_reg <= jmp_pend_reg ? jmp_addr_reg : i_pc;
            noadv_reg    <= jmp_pend_reg;
            jmp_pend_reg <= 1'b0;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          if (i_mem_rdy) begin
            mem_rd_reg <= 1'b0;
            state_reg  <= IDLE;
          end else if (i_jump) begin
            state_reg <= DROP;
          end
        end
        DROP: begin
          // Keep the stale request asserted until memory completes it, then throw the data away.
          if (i_mem_rdy) begin
            mem_rd_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (i_jump) begin
        count_reg  <= '0;
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        if (push) begin
          mem_reg[wr_ptr_reg] <= i_mem_data;
          wr_ptr_reg          <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Scoreboard bench for ins_fetch_unit: PC calculator and memory models around the DUT,
// directed scenarios push expected fetches/instructions, a monitor pops and compares.
module tb_ins_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] i_pc;
  logic       i_jump = 1'b0;
  logic       o_ins_pc_oen;
  logic       o_mem_rd;
  logic [7:0] o_mem_addr;
  logic       i_mem_rdy;
  logic [7:0] i_mem_data;
  logic [7:0] o_ins;
  logic       o_ins_valid;
  logic       i_ins_ready = 1'b0;

  logic [7:0] pc_reg;
  logic [7:0] jump_target = 8'h00;
  int         n_wait = 0;
  int         wait_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic       oen;
  } fetch_t;

  fetch_t     exp_fetch[$];
  logic [7:0] exp_ins[$];

  ins_fetch_unit #(.DATA_WIDTH(8), .INS_WIDTH(8), .FIFO_DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_pc(i_pc),
    .i_jump(i_jump),
    .o_ins_pc_oen(o_ins_pc_oen),
    .o_mem_rd(o_mem_rd),
    .o_mem_addr(o_mem_addr),
    .i_mem_rdy(i_mem_rdy),
    .i_mem_data(i_mem_data),
    .o_ins(o_ins),
    .o_ins_valid(o_ins_valid),
    .i_ins_ready(i_ins_ready)
  );

  always #5 clk = ~clk;

  // PC calculator: shows the target in a jump cycle and moves past it; advances on each strobe.
  assign i_pc = i_jump ? jump_target : pc_reg;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pc_reg <= 8'h00;
    else if (i_jump)       pc_reg <= jump_target + 8'h01;
    else if (o_ins_pc_oen) pc_reg <= pc_reg + 8'h01;
  end

  // Memory: mem[a] = a + 8'h10, answering after n_wait low-rdy cycles.
  assign i_mem_rdy  = o_mem_rd && (wait_cnt >= n_wait);
  assign i_mem_data = o_mem_addr + 8'h10;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       wait_cnt <= 0;
    else if (o_mem_rd && i_mem_rdy)   wait_cnt <= 0;
    else if (o_mem_rd)                wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic exp_f(input logic [7:0] a, input logic s);
    exp_fetch.push_back('{addr: a, oen: s});
  endtask

  // Monitor: compares every completed fetch and every decoder pop against the queues.
  logic       prev_wait = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  always @(negedge clk) begin
    fetch_t     f;
    logic [7:0] e;
    if (!rst_n) begin
      prev_wait = 1'b0;
    end else begin
      n_cmp++;
      if (o_mem_rd && i_mem_rdy) begin
        if (exp_fetch.size() == 0) begin
          n_fail++;
          $display("FAIL fetch: unexpected addr %h strobe %b, none required", o_mem_addr, o_ins_pc_oen);
        end else begin
          f = exp_fetch.pop_front();
          if (o_mem_addr !== f.addr || o_ins_pc_oen !== f.oen) begin
            n_fail++;
            $display("FAIL fetch: got addr %h strobe %b, required addr %h strobe %b",
                     o_mem_addr, o_ins_pc_oen, f.addr, f.oen);
          end else begin
            $display("fetch addr %h strobe %b", o_mem_addr, o_ins_pc_oen);
          end
        end
      end else if (o_ins_pc_oen !== 1'b0) begin
        n_fail++;
        $display("FAIL strobe_outside_rdy: got %b, required 0", o_ins_pc_oen);
      end
      if (prev_wait) begin
        n_cmp++;
        if (o_mem_rd !== 1'b1 || o_mem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL addr_hold: got rd %b addr %h, required rd 1 addr %h", o_mem_rd, o_mem_addr, prev_addr);
        end
      end
      prev_wait = o_mem_rd && !i_mem_rdy;
      prev_addr = o_mem_addr;
      if (o_ins_valid && i_ins_ready) begin
        n_cmp++;
        if (exp_ins.size() == 0) begin
          n_fail++;
          $display("FAIL ins: unexpected %h, none required", o_ins);
        end else begin
          e = exp_ins.pop_front();
          if (o_ins !== e) begin
            n_fail++;
            $display("FAIL ins: got %h, required %h", o_ins, e);
          end else begin
            $display("ins %h", o_ins);
          end
        end
      end
    end
  end

  // Called just after a monitor sample; asserts reset between clock edges.
  task automatic enter_reset();
    #2;
    check("fetch_queue_drained", exp_fetch.size(), 0);
    check("ins_queue_drained", exp_ins.size(), 0);
    exp_fetch.delete();
    exp_ins.delete();
    rst_n = 1'b0;
    #1;
    check("rst_mem_rd", o_mem_rd, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_pc_oen", o_ins_pc_oen, 0);
    check("rst_ins_valid", o_ins_valid, 0);
    check("rst_ins", o_ins, 0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    enter_reset();

    // Zero-wait memory, decoder always ready.
    n_wait = 0; i_ins_ready = 1'b1;
    exp_f(8'h00, 1); exp_f(8'h01, 1); exp_f(8'h02, 1); exp_f(8'h03, 1);
    exp_ins.push_back(8'h10); exp_ins.push_back(8'h11);
    exp_ins.push_back(8'h12); exp_ins.push_back(8'h13);
    release_reset();
    repeat (8) @(posedge clk);
    @(negedge clk);
    enter_reset();

    // Backpressure: two fetches fill the buffer, then fetching stalls until drained.
    n_wait = 0; i_ins_ready = 1'b0;
    exp_f(8'h00, 1); exp_f(8'h01, 1); exp_f(8'h02, 1); exp_f(8'h03, 1);
    exp_ins.push_back(8'h10); exp_ins.push_back(8'h11);
    exp_ins.push_back(8'h12); exp_ins.push_back(8'h13);
    release_reset();
    repeat (4) @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      check("bp_no_rd", o_mem_rd, 0);
      check("bp_head", {o_ins_valid, o_ins}, {1'b1, 8'h10});
    end
    @(posedge clk);
    #1 i_ins_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    enter_reset();

    // Three wait states per read.
    n_wait = 3; i_ins_ready = 1'b1;
    exp_f(8'h00, 1); exp_f(8'h01, 1); exp_f(8'h02, 1);
    exp_ins.push_back(8'h10); exp_ins.push_back(8'h11); exp_ins.push_back(8'h12);
    release_reset();
    repeat (15) @(posedge clk);
    @(negedge clk);
    enter_reset();

    // Jump to 8'h40 while idle with one entry buffered.
    n_wait = 0; i_ins_ready = 1'b0;
    exp_f(8'h00, 1); exp_f(8'h40, 0); exp_f(8'h41, 1);
    exp_ins.push_back(8'h50); exp_ins.push_back(8'h51);
    release_reset();
    repeat (2) @(posedge clk);
    #1 jump_target = 8'h40; i_jump = 1'b1;
    @(negedge clk);
    check("jmp_valid_drop", o_ins_valid, 0);
    @(posedge clk);
    #1 i_jump = 1'b0;
    @(negedge clk);
    check("jmp_fifo_empty", o_ins_valid, 0);
    repeat (4) @(posedge clk);
    #1 i_ins_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enter_reset();

    // Jump to 8'h20 during a pending read; stale data is dropped.
    n_wait = 2; i_ins_ready = 1'b1;
    exp_f(8'h00, 0); exp_f(8'h20, 0); exp_f(8'h21, 1);
    exp_ins.push_back(8'h30); exp_ins.push_back(8'h31);
    release_reset();
    @(posedge clk);
    #1 jump_target = 8'h20; i_jump = 1'b1;
    @(posedge clk);
    #1 i_jump = 1'b0;
    @(negedge clk);
    check("drop_hold_rd", o_mem_rd, 1);
    check("drop_hold_addr", o_mem_addr, 8'h00);
    repeat (10) @(posedge clk);
    @(negedge clk);
    enter_reset();

    // Asynchronous reset in the middle of a read at address 1.
    n_wait = 3; i_ins_ready = 1'b1;
    exp_f(8'h00, 1);
    exp_ins.push_back(8'h10);
    release_reset();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mid_req_rd", o_mem_rd, 1);
    check("mid_req_addr", o_mem_addr, 8'h01);
    enter_reset();

    n_wait = 0; i_ins_ready = 1'b1;
    exp_f(8'h00, 1); exp_f(8'h01, 1);
    exp_ins.push_back(8'h10); exp_ins.push_back(8'h11);
    release_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    enter_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
